controller_responder: RTL
=========================

Name: controller_responder

Overview:
- Device-side end of the serial game-controller link. It answers a host that drives latch and pulse and samples data.
- Parallel-loads NUM_BUTTONS active-high button levels when the host latches. Presents one bit per host pulse on the serial data line.
- Sits on the controller board between the button inputs and the GPIO pins that go to the host.
- latch and pulse are asynchronous to clk and are synchronized internally.

Parameters:
- NUM_BUTTONS, 8, number of buttons shifted per frame (2..32).
- SYNC_STAGES, 2, flip-flop stages in each input synchronizer (2..4).
- DATA_ACTIVE_LOW, 1, 1: data pin is low for a pressed button and high for idle/fill; 0: data pin is high for pressed.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- buttons  input  NUM_BUTTONS  live button levels, 1 = pressed; bit 0 is shifted out first.
- latch  input  1  host latch, asynchronous.
- pulse  input  1  host shift clock, asynchronous.
- data  output  1  serial button bit to host.
- bit_idx  output  $clog2(NUM_BUTTONS+1)  index of the bit currently on data; saturates at NUM_BUTTONS.
- busy  output  1  high while a latched frame is being shifted out.
- frame_done  output  1  one-cycle strobe when the last button bit is shifted past.

Behaviour:
- Synchronizers: latch and pulse each pass through SYNC_STAGES flops, then one edge-detect flop.
  - A rise or fall is detected SYNC_STAGES+1 clk cycles after the pin changes.
  - Host pulse/latch high and low times must each be at least SYNC_STAGES+2 clk periods; shorter pulses may be missed.
- Internal register: shreg[NUM_BUTTONS-1:0], active-high pressed. data = shreg[0] XOR DATA_ACTIVE_LOW, registered (no combinational path from pins).
- State machine:
  - IDLE to LOAD: on a synchronized latch rise.
  - LOAD: shreg <= buttons every cycle (transparent reload), bit_idx <= 0, busy = 0.
  - LOAD to SHIFT: on the latch fall. shreg keeps the last value loaded; busy <= 1.
  - SHIFT, on each synchronized pulse rise:
    - shreg <= {1'b0, shreg[NUM_BUTTONS-1:1]}; the fill value is not-pressed.
    - bit_idx <= bit_idx + 1.
    - data updates on the same cycle that shreg updates, i.e. one cycle after edge detection.
  - SHIFT to IDLE: on the pulse rise that makes bit_idx reach NUM_BUTTONS. frame_done = 1 for that one cycle; busy <= 0.
  - IDLE: further pulse rises keep shifting in 0; data stays at the idle level; bit_idx holds NUM_BUTTONS; frame_done does not repeat.
- Boundary conditions:
  - Pulse rise while latch is synchronized high: ignored (no shift, no count).
  - Latch rise and pulse rise detected on the same cycle: latch wins and the pulse is dropped.
  - Latch rise during SHIFT (host aborts the frame): go to LOAD immediately; busy <= 0; no frame_done.
  - bit_idx never wraps; it saturates at NUM_BUTTONS.
- Reset, taking effect at the next clk edge regardless of state:
  - State IDLE, shreg = 0, bit_idx = NUM_BUTTONS, busy = 0, frame_done = 0.
  - data = idle level (1 when DATA_ACTIVE_LOW = 1).
  - Synchronizer flops cleared to 0. A latch already high at reset release is therefore detected as a rise.

Optional Feature:
- Macro: CONTROLLER_RESPONDER_TURBO_EN.
- When defined:
  - Adds port turbo_mask input NUM_BUTTONS and parameter TURBO_FRAMES (default 4).
  - A frame counter counts synchronized latch rises. turbo_phase toggles every TURBO_FRAMES rises; counter and phase reset to 0.
  - LOAD captures buttons & ~(turbo_mask & {NUM_BUTTONS{turbo_phase}}), so held turbo buttons alternate pressed/released in blocks of TURBO_FRAMES frames.
- When undefined: the port, parameter and counter are absent; LOAD captures buttons unmodified.

Test Plan:
- Reset, then buttons=8'b0000_0101, latch pulsed high 4 cycles then low -> data=0 (A pressed, active-low), busy=1, bit_idx=0.
- Then 8 pulses -> data sequence after each pulse 1,0,1,1,1,1,1,1. frame_done strobes once on the 8th, with bit_idx=8 and busy=0. A 9th pulse leaves data=1 and gives no strobe.
- Change buttons from 8'h01 to 8'h02 while latch is high -> shreg follows live. On latch fall with 8'h02, data=1 then 0 after the first pulse.
- Latch rise after 3 of 8 pulses with buttons=8'hFF -> bit_idx=0, busy=0, no frame_done, data=0.
- Pulse and latch rising on the same clk edge -> the reload occurs and bit_idx stays 0.
- With CONTROLLER_RESPONDER_TURBO_EN, TURBO_FRAMES=2, turbo_mask=8'h01, buttons=8'h01 -> first-bit data across frames 1..6 is 0,0,1,1,0,0.

Source files
------------

// File: rtl/controller_responder.sv
// rtl/controller_responder.sv - device-side serial game-controller responder (latch/pulse shift-out)
// Optional turbo-fire masking is enabled with CONTROLLER_RESPONDER_TURBO_EN.
module controller_responder #(
    parameter int NUM_BUTTONS     = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DATA_ACTIVE_LOW = 1
`ifdef CONTROLLER_RESPONDER_TURBO_EN
    ,
    parameter int TURBO_FRAMES    = 4
`endif
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_BUTTONS-1:0]             buttons,
`ifdef CONTROLLER_RESPONDER_TURBO_EN
    input  logic [NUM_BUTTONS-1:0]             turbo_mask,
`endif
    input  logic                               latch,
    input  logic                               pulse,
    output logic                               data,
    output logic [$clog2(NUM_BUTTONS+1)-1:0]   bit_idx,
    output logic                               busy,
    output logic                               frame_done
);

    localparam int IW = $clog2(NUM_BUTTONS + 1);
    localparam logic [IW-1:0] N_IDX = IW'(NUM_BUTTONS);
    localparam logic DAL = (DATA_ACTIVE_LOW != 0);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT} state_t;

    state_t                   state_q;
    logic [NUM_BUTTONS-1:0]   shreg_q;
    logic [NUM_BUTTONS-1:0]   shreg_d;
    logic [NUM_BUTTONS-1:0]   load_val;
    logic [IW-1:0]            bit_idx_q;
    logic                     data_q;
    logic                     busy_q;
    logic                     frame_done_q;

    logic [SYNC_STAGES-1:0]   latch_sync_q;
    logic [SYNC_STAGES-1:0]   pulse_sync_q;
    logic                     latch_prev_q;
    logic                     pulse_prev_q;
    logic                     latch_s;
    logic                     pulse_s;
    logic                     latch_rise;
    logic                     latch_fall;
    logic                     pulse_rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            latch_sync_q <= '0;
            pulse_sync_q <= '0;
            latch_prev_q <= 1'b0;
            pulse_prev_q <= 1'b0;
        end else begin
            latch_sync_q <= {latch_sync_q[SYNC_STAGES-2:0], latch};
            pulse_sync_q <= {pulse_sync_q[SYNC_STAGES-2:0], pulse};
            latch_prev_q <= latch_s;
            pulse_prev_q <= pulse_s;
        end
    end

    assign latch_s    = latch_sync_q[SYNC_STAGES-1];
    assign pulse_s    = pulse_sync_q[SYNC_STAGES-1];
    assign latch_rise = latch_s & ~latch_prev_q;
    assign latch_fall = ~latch_s & latch_prev_q;
    assign pulse_rise = pulse_s & ~pulse_prev_q;

    assign shreg_d = {1'b0, shreg_q[NUM_BUTTONS-1:1]};

`ifdef CONTROLLER_RESPONDER_TURBO_EN
    localparam int TW = $clog2(TURBO_FRAMES + 1);
    logic [TW-1:0] turbo_cnt_q;
    logic          turbo_phase_q;

    // Phase flips on the first rise of each new block, so frames 1..TURBO_FRAMES use phase 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            turbo_cnt_q   <= '0;
            turbo_phase_q <= 1'b0;
        end else if (latch_rise) begin
            if (turbo_cnt_q == TW'(TURBO_FRAMES)) begin
                turbo_cnt_q   <= TW'(1);
                turbo_phase_q <= ~turbo_phase_q;
            end else begin
                turbo_cnt_q   <= turbo_cnt_q + TW'(1);
            end
        end
    end

    assign load_val = buttons & ~(turbo_mask & {NUM_BUTTONS{turbo_phase_q}});
`else
    assign load_val = buttons;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            shreg_q      <= '0;
            bit_idx_q    <= N_IDX;
            data_q       <= DAL;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (latch_rise) begin
                // A latch rise always restarts the frame, even mid-shift, and swallows a coincident pulse.
                state_q   <= S_LOAD;
                shreg_q   <= load_val;
                data_q    <= load_val[0] ^ DAL;
                bit_idx_q <= '0;
                busy_q    <= 1'b0;
            end else begin
                case (state_q)
                    S_LOAD: begin
                        if (latch_fall) begin
                            state_q <= S_SHIFT;
                            busy_q  <= 1'b1;
                        end else begin
                            shreg_q   <= load_val;
                            data_q    <= load_val[0] ^ DAL;
                            bit_idx_q <= '0;
                        end
                    end
                    S_SHIFT: begin
                        if (pulse_rise && !latch_s) begin
                            shreg_q   <= shreg_d;
                            data_q    <= shreg_d[0] ^ DAL;
                            bit_idx_q <= bit_idx_q + IW'(1);
                            if (bit_idx_q + IW'(1) == N_IDX) begin
                                state_q      <= S_IDLE;
                                frame_done_q <= 1'b1;
                                busy_q       <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        if (pulse_rise && !latch_s) begin
                            shreg_q <= shreg_d;
                            data_q  <= shreg_d[0] ^ DAL;
                        end
                    end
                endcase
            end
        end
    end

    assign data       = data_q;
    assign bit_idx    = bit_idx_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule
